z80fi_insn_capture: RTL and testbench

Upstream producer for the z80fi instruction-spec modules. It observes the core's per-instruction events: instruction start, opcode/operand byte fetches, data memory writes and retirement. From these it assembles one z80fi retirement record per instruction (insn word, insn_len, register snapshots, memory write records). The record is presented for exactly one cycle with z80fi_valid. Every insn_spec module and the checker consume this record in parallel.

---
 rtl/z80fi_insn_capture.sv | 191 +++++++++++++++++++
 tb/tb_z80fi_insn_capture.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80fi_insn_capture.sv
// Assembles one z80fi retirement record per instruction; record pulses z80fi_valid one cycle after insn_done.
// No backpressure: events are taken every cycle, overflow sets sticky err. Optional reads: Z80FI_MEM_RD_EN.
module z80fi_insn_capture #(
   parameter int MAX_INSN_BYTES = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        core_insn_start,
   input  logic [15:0] core_reg_ip,
   input  logic [15:0] core_reg_bc,
   input  logic [15:0] core_reg_de,
   input  logic [15:0] core_reg_hl,
   input  logic [15:0] core_reg_sp,
   input  logic        core_fetch_valid,
   input  logic [7:0]  core_fetch_data,
   input  logic        core_mem_wr,
   input  logic [15:0] core_mem_waddr,
   input  logic [7:0]  core_mem_wdata,
   input  logic        core_insn_done,
   output logic        z80fi_valid,
   output logic [31:0] z80fi_insn,
   output logic [2:0]  z80fi_insn_len,
   output logic [15:0] z80fi_reg_ip_in,
   output logic [15:0] z80fi_reg_bc_in,
   output logic [15:0] z80fi_reg_de_in,
   output logic [15:0] z80fi_reg_hl_in,
   output logic [15:0] z80fi_reg_sp_in,
   output logic        z80fi_mem_wr,
   output logic [15:0] z80fi_mem_waddr,
   output logic [7:0]  z80fi_mem_wdata,
   output logic        z80fi_mem_wr2,
   output logic [15:0] z80fi_mem_waddr2,
   output logic [7:0]  z80fi_mem_wdata2,
   output logic        z80fi_capture_err
`ifdef Z80FI_MEM_RD_EN
   ,
   input  logic        core_mem_rd,
   input  logic [15:0] core_mem_raddr,
   input  logic [7:0]  core_mem_rdata,
   output logic        z80fi_mem_rd,
   output logic [15:0] z80fi_mem_raddr,
   output logic [7:0]  z80fi_mem_rdata
`endif
);

   localparam logic [0:0] IDLE    = 1'b0;
   localparam logic [0:0] CAPTURE = 1'b1;
   localparam logic [2:0] LEN_MAX = 3'(MAX_INSN_BYTES);

   typedef struct packed {
      logic [15:0] ip;
      logic [15:0] bc;
      logic [15:0] de;
      logic [15:0] hl;
      logic [15:0] sp;
      logic [31:0] insn;
      logic [2:0]  len;
      logic        wr;
      logic [15:0] waddr;
      logic [7:0]  wdata;
      logic        wr2;
      logic [15:0] waddr2;
      logic [7:0]  wdata2;
`ifdef Z80FI_MEM_RD_EN
      logic        rd;
      logic [15:0] raddr;
      logic [7:0]  rdata;
`endif
   } rec_t;

   logic [0:0] state;
   rec_t       cap;
   rec_t       outr;
   rec_t       fresh;
   rec_t       base;
   rec_t       upd;
   logic       emit;
   logic       restart;
   logic       live;
   logic       ovf;
   logic       valid_q;
   logic       err_q;

   // Events in a done cycle belong to the retiring record; a restart
   // (start without done) applies the cycle's events to the fresh record.
   always_comb begin
      fresh    = '0;
      fresh.ip = core_reg_ip;
      fresh.bc = core_reg_bc;
      fresh.de = core_reg_de;
      fresh.hl = core_reg_hl;
      fresh.sp = core_reg_sp;

      emit    = (state == CAPTURE) && core_insn_done;
      restart = core_insn_start && !emit;
      live    = (state == CAPTURE) || core_insn_start;
      base    = restart ? fresh : cap;

      upd = base;
      ovf = 1'b0;
      if (core_fetch_valid) begin
         if (base.len >= LEN_MAX) begin
            ovf = 1'b1;
         end else begin
            for (int k = 0; k < MAX_INSN_BYTES; k++) begin
               if (base.len == 3'(k)) upd.insn[8*k +: 8] = core_fetch_data;
            end
            upd.len = base.len + 3'd1;
         end
      end
      if (core_mem_wr) begin
         if (!base.wr) begin
            upd.wr    = 1'b1;
            upd.waddr = core_mem_waddr;
            upd.wdata = core_mem_wdata;
         end else if (!base.wr2) begin
            upd.wr2    = 1'b1;
            upd.waddr2 = core_mem_waddr;
            upd.wdata2 = core_mem_wdata;
         end else begin
            ovf = 1'b1;
         end
      end
`ifdef Z80FI_MEM_RD_EN
      if (core_mem_rd) begin
         if (!base.rd) begin
            upd.rd    = 1'b1;
            upd.raddr = core_mem_raddr;
            upd.rdata = core_mem_rdata;
         end else begin
            ovf = 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= IDLE;
         cap     <= '0;
         outr    <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         valid_q <= emit;
         if (emit) begin
            outr <= upd;
            // Back-to-back: the new instruction starts in a clean shadow record.
            if (core_insn_start) begin
               cap   <= fresh;
               state <= CAPTURE;
            end else begin
               state <= IDLE;
            end
         end else if (core_insn_start) begin
            cap   <= upd;
            state <= CAPTURE;
         end else if (state == CAPTURE) begin
            cap <= upd;
         end

         if ((live && ovf) ||
             ((state == IDLE) && core_insn_done) ||
             ((state == CAPTURE) && core_insn_start && !core_insn_done)) begin
            err_q <= 1'b1;
         end
      end
   end

   assign z80fi_valid       = valid_q;
   assign z80fi_insn        = outr.insn;
   assign z80fi_insn_len    = outr.len;
   assign z80fi_reg_ip_in   = outr.ip;
   assign z80fi_reg_bc_in   = outr.bc;
   assign z80fi_reg_de_in   = outr.de;
   assign z80fi_reg_hl_in   = outr.hl;
   assign z80fi_reg_sp_in   = outr.sp;
   assign z80fi_mem_wr      = outr.wr;
   assign z80fi_mem_waddr   = outr.waddr;
   assign z80fi_mem_wdata   = outr.wdata;
   assign z80fi_mem_wr2     = outr.wr2;
   assign z80fi_mem_waddr2  = outr.waddr2;
   assign z80fi_mem_wdata2  = outr.wdata2;
   assign z80fi_capture_err = err_q;
`ifdef Z80FI_MEM_RD_EN
   assign z80fi_mem_rd      = outr.rd;
   assign z80fi_mem_raddr   = outr.raddr;
   assign z80fi_mem_rdata   = outr.rdata;
`endif

endmodule

// File: tb/tb_z80fi_insn_capture.sv
// Bench for z80fi_insn_capture: queue-based record model checked every cycle, plus literal directed cases.
module tb_z80fi_insn_capture;

   localparam int MAX = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        core_insn_start;
   logic [15:0] core_reg_ip, core_reg_bc, core_reg_de, core_reg_hl, core_reg_sp;
   logic        core_fetch_valid;
   logic [7:0]  core_fetch_data;
   logic        core_mem_wr;
   logic [15:0] core_mem_waddr;
   logic [7:0]  core_mem_wdata;
   logic        core_insn_done;
   logic        z80fi_valid;
   logic [31:0] z80fi_insn;
   logic [2:0]  z80fi_insn_len;
   logic [15:0] z80fi_reg_ip_in, z80fi_reg_bc_in, z80fi_reg_de_in, z80fi_reg_hl_in, z80fi_reg_sp_in;
   logic        z80fi_mem_wr, z80fi_mem_wr2;
   logic [15:0] z80fi_mem_waddr, z80fi_mem_waddr2;
   logic [7:0]  z80fi_mem_wdata, z80fi_mem_wdata2;
   logic        z80fi_capture_err;
`ifdef Z80FI_MEM_RD_EN
   logic        core_mem_rd;
   logic [15:0] core_mem_raddr;
   logic [7:0]  core_mem_rdata;
   logic        z80fi_mem_rd;
   logic [15:0] z80fi_mem_raddr;
   logic [7:0]  z80fi_mem_rdata;
`endif

   z80fi_insn_capture #(.MAX_INSN_BYTES(MAX)) dut (
      .clk(clk), .reset_n(reset_n),
      .core_insn_start(core_insn_start),
      .core_reg_ip(core_reg_ip), .core_reg_bc(core_reg_bc), .core_reg_de(core_reg_de),
      .core_reg_hl(core_reg_hl), .core_reg_sp(core_reg_sp),
      .core_fetch_valid(core_fetch_valid), .core_fetch_data(core_fetch_data),
      .core_mem_wr(core_mem_wr), .core_mem_waddr(core_mem_waddr), .core_mem_wdata(core_mem_wdata),
      .core_insn_done(core_insn_done),
      .z80fi_valid(z80fi_valid), .z80fi_insn(z80fi_insn), .z80fi_insn_len(z80fi_insn_len),
      .z80fi_reg_ip_in(z80fi_reg_ip_in), .z80fi_reg_bc_in(z80fi_reg_bc_in),
      .z80fi_reg_de_in(z80fi_reg_de_in), .z80fi_reg_hl_in(z80fi_reg_hl_in),
      .z80fi_reg_sp_in(z80fi_reg_sp_in),
      .z80fi_mem_wr(z80fi_mem_wr), .z80fi_mem_waddr(z80fi_mem_waddr), .z80fi_mem_wdata(z80fi_mem_wdata),
      .z80fi_mem_wr2(z80fi_mem_wr2), .z80fi_mem_waddr2(z80fi_mem_waddr2), .z80fi_mem_wdata2(z80fi_mem_wdata2),
      .z80fi_capture_err(z80fi_capture_err)
`ifdef Z80FI_MEM_RD_EN
      ,
      .core_mem_rd(core_mem_rd), .core_mem_raddr(core_mem_raddr), .core_mem_rdata(core_mem_rdata),
      .z80fi_mem_rd(z80fi_mem_rd), .z80fi_mem_raddr(z80fi_mem_raddr), .z80fi_mem_rdata(z80fi_mem_rdata)
`endif
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Model: the open instruction as queues of bytes and writes, plus the last emitted record.
   bit          m_in;
   logic [7:0]  m_b[$];
   logic [15:0] m_wa[$];
   logic [7:0]  m_wd[$];
   logic [15:0] m_ip, m_bc, m_de, m_hl, m_sp;
   logic        e_valid, e_err;
   logic [31:0] e_insn;
   logic [2:0]  e_len;
   logic [15:0] e_ip, e_bc, e_de, e_hl, e_sp, e_wa, e_wa2;
   logic        e_wr, e_wr2;
   logic [7:0]  e_wd, e_wd2;
`ifdef Z80FI_MEM_RD_EN
   logic [15:0] m_ra[$];
   logic [7:0]  m_rd[$];
   logic        e_rd;
   logic [15:0] e_ra;
   logic [7:0]  e_rdd;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_model();
      m_in = 0; m_b.delete(); m_wa.delete(); m_wd.delete();
      {e_valid, e_err, e_insn, e_len, e_ip, e_bc, e_de, e_hl, e_sp} = '0;
      {e_wr, e_wa, e_wd, e_wr2, e_wa2, e_wd2} = '0;
`ifdef Z80FI_MEM_RD_EN
      m_ra.delete(); m_rd.delete(); {e_rd, e_ra, e_rdd} = '0;
`endif
   endtask

   task automatic new_insn();
      m_b.delete(); m_wa.delete(); m_wd.delete();
`ifdef Z80FI_MEM_RD_EN
      m_ra.delete(); m_rd.delete();
`endif
      m_ip = core_reg_ip; m_bc = core_reg_bc; m_de = core_reg_de; m_hl = core_reg_hl; m_sp = core_reg_sp;
   endtask

   task automatic apply_events();
      if (core_fetch_valid) begin
         if (m_b.size() < MAX) m_b.push_back(core_fetch_data); else e_err = 1;
      end
      if (core_mem_wr) begin
         if (m_wa.size() < 2) begin m_wa.push_back(core_mem_waddr); m_wd.push_back(core_mem_wdata); end
         else e_err = 1;
      end
`ifdef Z80FI_MEM_RD_EN
      if (core_mem_rd) begin
         if (m_ra.size() < 1) begin m_ra.push_back(core_mem_raddr); m_rd.push_back(core_mem_rdata); end
         else e_err = 1;
      end
`endif
   endtask

   task automatic emit_rec();
      e_valid = 1;
      e_insn = 0;
      foreach (m_b[k]) e_insn = e_insn | (32'(m_b[k]) << (8 * k));
      e_len = 3'(m_b.size());
      e_ip = m_ip; e_bc = m_bc; e_de = m_de; e_hl = m_hl; e_sp = m_sp;
      e_wr  = m_wa.size() > 0; e_wa  = e_wr  ? m_wa[0] : 16'h0; e_wd  = e_wr  ? m_wd[0] : 8'h0;
      e_wr2 = m_wa.size() > 1; e_wa2 = e_wr2 ? m_wa[1] : 16'h0; e_wd2 = e_wr2 ? m_wd[1] : 8'h0;
`ifdef Z80FI_MEM_RD_EN
      e_rd = m_ra.size() > 0; e_ra = e_rd ? m_ra[0] : 16'h0; e_rdd = e_rd ? m_rd[0] : 8'h0;
`endif
   endtask

   task automatic model_update();
      if (!reset_n) begin
         clear_model();
      end else begin
         e_valid = 0;
         if (m_in && core_insn_done) begin
            apply_events();
            emit_rec();
            if (core_insn_start) new_insn(); else m_in = 0;
         end else begin
            if (core_insn_done) e_err = 1;
            if (core_insn_start) begin
               if (m_in) e_err = 1;
               new_insn();
               m_in = 1;
               apply_events();
            end else if (m_in) begin
               apply_events();
            end
         end
      end
   endtask

   task automatic check_all();
      chk("valid", z80fi_valid, e_valid);
      chk("err", z80fi_capture_err, e_err);
      chk("insn", z80fi_insn, e_insn);
      chk("len", z80fi_insn_len, e_len);
      chk("ip", z80fi_reg_ip_in, e_ip);
      chk("bc", z80fi_reg_bc_in, e_bc);
      chk("de", z80fi_reg_de_in, e_de);
      chk("hl", z80fi_reg_hl_in, e_hl);
      chk("sp", z80fi_reg_sp_in, e_sp);
      chk("wr", {z80fi_mem_wr, z80fi_mem_wdata, z80fi_mem_waddr}, {e_wr, e_wd, e_wa});
      chk("wr2", {z80fi_mem_wr2, z80fi_mem_wdata2, z80fi_mem_waddr2}, {e_wr2, e_wd2, e_wa2});
`ifdef Z80FI_MEM_RD_EN
      chk("rd", {z80fi_mem_rd, z80fi_mem_rdata, z80fi_mem_raddr}, {e_rd, e_rdd, e_ra});
`endif
   endtask

   task automatic step();
      model_update();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic idle();
      reset_n = 1; core_insn_start = 0; core_fetch_valid = 0; core_mem_wr = 0; core_insn_done = 0;
      core_fetch_data = 0; core_mem_waddr = 0; core_mem_wdata = 0;
      core_reg_ip = 0; core_reg_bc = 0; core_reg_de = 0; core_reg_hl = 0; core_reg_sp = 0;
`ifdef Z80FI_MEM_RD_EN
      core_mem_rd = 0; core_mem_raddr = 0; core_mem_rdata = 0;
`endif
   endtask

   task automatic fetch(input logic [7:0] b);
      core_fetch_valid = 1; core_fetch_data = b;
   endtask

   task automatic do_reset();
      idle(); reset_n = 0; step(); step(); idle();
   endtask

   int pulses;

   initial begin
      clear_model();
      do_reset();
      chk("reset_valid", z80fi_valid, 0);
      chk("reset_insn", z80fi_insn, 0);
      chk("reset_err", z80fi_capture_err, 0);

      // LD (0x1234),DE
      idle(); core_insn_start = 1; core_reg_ip = 16'h0100; core_reg_de = 16'hBEEF;
      core_reg_bc = 16'h1111; core_reg_hl = 16'h2222; core_reg_sp = 16'hFFF0; fetch(8'hED); step();
      idle(); fetch(8'h53); step();
      idle(); fetch(8'h34); step();
      idle(); fetch(8'h12); core_mem_wr = 1; core_mem_waddr = 16'h1234; core_mem_wdata = 8'hEF; step();
      idle(); core_mem_wr = 1; core_mem_waddr = 16'h1235; core_mem_wdata = 8'hBE; step();
      chk("ld_no_valid_yet", z80fi_valid, 0);
      idle(); core_insn_done = 1; step();
      chk("ld_valid", z80fi_valid, 1);
      chk("ld_insn", z80fi_insn, 32'h123453ED);
      chk("ld_len", z80fi_insn_len, 4);
      chk("ld_ip", z80fi_reg_ip_in, 16'h0100);
      chk("ld_de", z80fi_reg_de_in, 16'hBEEF);
      chk("ld_wr", {z80fi_mem_wr, z80fi_mem_waddr, z80fi_mem_wdata}, {1'b1, 16'h1234, 8'hEF});
      chk("ld_wr2", {z80fi_mem_wr2, z80fi_mem_waddr2, z80fi_mem_wdata2}, {1'b1, 16'h1235, 8'hBE});
      idle(); step();
      chk("ld_pulse_one_cycle", z80fi_valid, 0);
      chk("ld_hold", z80fi_insn, 32'h123453ED);

      // NOP
      idle(); core_insn_start = 1; fetch(8'h00); step();
      idle(); core_insn_done = 1; step();
      chk("nop_valid", z80fi_valid, 1);
      chk("nop_insn", z80fi_insn, 0);
      chk("nop_len", z80fi_insn_len, 1);
      chk("nop_wr", {z80fi_mem_wr, z80fi_mem_wr2}, 0);
      chk("nop_err", z80fi_capture_err, 0);

      // Back-to-back: A = LD A,7 ; B = NOP at 0x0105
      pulses = 0;
      idle(); core_insn_start = 1; core_reg_ip = 16'h0100; fetch(8'h3E); step();
      idle(); fetch(8'h07); step();
      idle(); core_insn_done = 1; core_insn_start = 1; core_reg_ip = 16'h0105; step();
      pulses += int'(z80fi_valid);
      chk("b2b_a_insn", z80fi_insn, 32'h0000073E);
      chk("b2b_a_len", z80fi_insn_len, 2);
      chk("b2b_a_ip", z80fi_reg_ip_in, 16'h0100);
      idle(); fetch(8'h00); step(); pulses += int'(z80fi_valid);
      idle(); core_insn_done = 1; step(); pulses += int'(z80fi_valid);
      chk("b2b_b_ip", z80fi_reg_ip_in, 16'h0105);
      chk("b2b_b_len", z80fi_insn_len, 1);
      idle(); step(); pulses += int'(z80fi_valid);
      chk("b2b_pulses", pulses, 2);
      chk("b2b_err", z80fi_capture_err, 0);

      // Reset mid-capture, with done arriving during the reset cycle
      pulses = 0;
      idle(); core_insn_start = 1; core_reg_ip = 16'h0200; fetch(8'h01); step();
      idle(); fetch(8'h02); step();
      idle(); reset_n = 0; core_insn_done = 1; step();
      chk("rst_insn", z80fi_insn, 0);
      chk("rst_ip", z80fi_reg_ip_in, 0);
      chk("rst_err", z80fi_capture_err, 0);
      idle(); step(); pulses += int'(z80fi_valid);
      step(); pulses += int'(z80fi_valid);
      chk("rst_no_pulse", pulses, 0);

`ifdef Z80FI_MEM_RD_EN
      // LD A,(0x4000)
      idle(); core_insn_start = 1; fetch(8'h3A); step();
      idle(); fetch(8'h00); step();
      idle(); fetch(8'h40); step();
      idle(); core_mem_rd = 1; core_mem_raddr = 16'h4000; core_mem_rdata = 8'h5A; core_insn_done = 1; step();
      chk("rd_rec", {z80fi_mem_rd, z80fi_mem_raddr, z80fi_mem_rdata}, {1'b1, 16'h4000, 8'h5A});
`endif

      // Overflow: five fetches
      idle(); core_insn_start = 1; fetch(8'hA1); step();
      for (int i = 2; i <= 5; i++) begin idle(); fetch(8'(8'hA0 + i)); step(); end
      chk("ovf_err_early", z80fi_capture_err, 1);
      idle(); core_insn_done = 1; step();
      chk("ovf_len", z80fi_insn_len, 4);
      chk("ovf_insn", z80fi_insn, 32'hA4A3A2A1);
      idle(); repeat (3) step();
      chk("ovf_err_sticky", z80fi_capture_err, 1);
      do_reset();
      chk("ovf_err_cleared", z80fi_capture_err, 0);

      // Randomized traffic against the model
      for (int c = 0; c < 4000; c++) begin
         idle();
         reset_n          = ($urandom_range(0, 199) != 0);
         core_insn_start  = ($urandom_range(0, 6) == 0);
         core_insn_done   = ($urandom_range(0, 5) == 0);
         core_fetch_valid = ($urandom_range(0, 1) == 0);
         core_mem_wr      = ($urandom_range(0, 3) == 0);
         core_fetch_data  = 8'($urandom);
         core_mem_waddr   = 16'($urandom);
         core_mem_wdata   = 8'($urandom);
         core_reg_ip = 16'($urandom); core_reg_bc = 16'($urandom); core_reg_de = 16'($urandom);
         core_reg_hl = 16'($urandom); core_reg_sp = 16'($urandom);
`ifdef Z80FI_MEM_RD_EN
         core_mem_rd    = ($urandom_range(0, 4) == 0);
         core_mem_raddr = 16'($urandom);
         core_mem_rdata = 8'($urandom);
`endif
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
